hazard_scoreboard_unit: RTL
===========================

# hazard_scoreboard_unit

Parametrised pipeline hazard controller for the five-stage core; next generation of the load-use stall detector. A per-register countdown scoreboard tracks in-flight loads, so load-use stalls scale to any load-to-forward latency (`LOAD_LAT`). A small FSM sequences multi-cycle `jr` redirect bubbles. Misprediction flushes take priority over both. Drives PC/IF_ID write enables and the IF_ID/ID_EX flush selects, and keeps saturating stall/flush event counters for profiling.

## Interface
- `REG_AW`, 5: register address width; `1<<REG_AW` scoreboard entries.
- `LOAD_LAT`, 1: stall cycles a dependent instruction waits behind a load (1 = single bubble). Range 1..7.
- `JR_BUBBLES`, 1: IF_ID flush cycles after a `jr` in ID. Range 1..4.
- `CNT_W`, 32: width of the event counters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `if_id_opcode` in 7: opcode of the instruction in ID.
- `if_id_rs1`, `if_id_rs2` in REG_AW: ID source registers.
- `if_id_use_rs1`, `if_id_use_rs2` in 1: source actually read.
- `if_id_memread` in 1: instruction in ID is a load.
- `if_id_rd` in REG_AW: ID destination register.
- `Wrong_prediction` in 1: branch resolved as mispredicted this cycle.
- `PC_Write` out 1: PC update enable.
- `if_id_Write` out 1: IF_ID update enable.
- `if_id_flush` out 1: zero IF_ID on the next edge.
- `id_ex_flush` out 1: inject bubble into ID_EX.
- `stall_count` out CNT_W: cycles with `PC_Write=0`, saturating.
- `flush_count` out CNT_W: `Wrong_prediction` cycles, saturating.

## Operation
- Scoreboard: `sb_cnt[r]`, `$clog2(LOAD_LAT+1)` bits per register. Entry 0 is never written and always reads 0.
- Load issue = `if_id_memread & ~load_stall & ~Wrong_prediction`. On issue, `sb_cnt[if_id_rd] <= LOAD_LAT` (if `rd≠0`).
- Every nonzero entry decrements by 1 each cycle. When issue and decrement hit the same entry, the set wins.
- `load_stall = (if_id_use_rs1 & sb_cnt[if_id_rs1]≠0) | (if_id_use_rs2 & sb_cnt[if_id_rs2]≠0)`.
- Control outputs are combinational from registered state and current inputs. Priority, first match wins:
  1. `Wrong_prediction`: PC_Write=1, if_id_Write=1, if_id_flush=1, id_ex_flush=1. FSM forced to IDLE. The ID instruction does not issue.
  2. `load_stall`: PC_Write=0, if_id_Write=0, if_id_flush=0, id_ex_flush=1.
  3. FSM in JR_DRAIN: PC_Write=1, if_id_Write=1, if_id_flush=1, id_ex_flush=0.
  4. `if_id_opcode==jr` in IDLE: PC_Write=0, if_id_Write=1, if_id_flush=1, id_ex_flush=0. If `JR_BUBBLES>1`, go to JR_DRAIN with `jr_cnt=JR_BUBBLES-1`.
  5. Otherwise (beq/bne included): PC_Write=1, if_id_Write=1, both flushes 0.
- FSM states:
  - IDLE → JR_DRAIN on rule 4.
  - JR_DRAIN decrements `jr_cnt` each cycle it is not pre-empted and returns to IDLE on the cycle it reaches 0.
  - `Wrong_prediction` returns the FSM to IDLE from any state.
- Counters increment by 1 per qualifying cycle and hold at `2^CNT_W-1`.
- Entries are not cleared on misprediction: loads already past ID still complete.

## Timing
- Reset (async, asserted low): all `sb_cnt`=0, FSM=IDLE, `jr_cnt`=0, counters=0. While `rst` is low, outputs are forced to PC_Write=1, if_id_Write=1, if_id_flush=0, id_ex_flush=0.
- Deassertion takes effect at the first rising edge with `rst` high.
- Dependent immediately behind a load sees exactly `LOAD_LAT` stall cycles.
- Dependent `k` instructions behind a load sees `max(0, LOAD_LAT-k+1)` stall cycles.
- `jr` costs exactly `JR_BUBBLES` flushed fetch cycles, plus any load stall cycles, which are served first.
- Reset asserted mid-stall or mid-drain: stall and drain end immediately and the reset values apply.

## Structure
- Shared `opcodes.v` include provides `jr`, `beq`, `bne`.
- Package-level localparams: the FSM state encoding `ST_IDLE`, `ST_JR_DRAIN`.
- Sub-module `load_scoreboard` holds the counter array, issue/decrement logic and the two-port `load_stall` lookup. The FSM, priority mux and counters stay in the top.

## Test plan
- `LOAD_LAT=1`, `lw x5` then `add x6,x5,x7` → exactly 1 cycle with PC_Write=0, id_ex_flush=1; `stall_count`=1.
- `LOAD_LAT=3`, `lw x5`, unrelated instruction, then a `x5` user → 2 stall cycles. A load to `x0` followed by an `x0` user → 0 stalls.
- `JR_BUBBLES=3`, `jr` in ID → cycle 0: PC_Write=0, if_id_flush=1; next 2 cycles: if_id_flush=1, PC_Write=1; then normal.
- `Wrong_prediction` raised while a load-use stall and JR_DRAIN are both pending → all four outputs go to the rule-1 pattern, FSM returns to IDLE, `flush_count` increments by 1, and the flushed load sets no scoreboard entry.
- `rst` pulled low mid-stall (`LOAD_LAT=4`) → outputs return to 1,1,0,0 immediately. After release a previous dependent does not stall, and the counters read 0.
- `CNT_W=3`, 10 stall cycles → `stall_count` saturates at 7.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// rtl/hazard_scoreboard_unit_pkg.sv - opcodes, FSM encoding and control patterns for the hazard unit
package hazard_scoreboard_unit_pkg;

  // Opcodes of the five-stage core that the hazard unit decodes or passes through
  localparam logic [6:0] OPC_JR  = 7'b0001000;
  localparam logic [6:0] OPC_BEQ = 7'b0000100;
  localparam logic [6:0] OPC_BNE = 7'b0000101;

  // jr redirect sequencer state encoding
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_JR_DRAIN = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE     = ST_IDLE,
    S_JR_DRAIN = ST_JR_DRAIN
  } jr_state_e;

  // Pipeline control bundle, MSB first: PC write, IF_ID write, IF_ID flush, ID_EX flush
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN     = 4'b1100;
  localparam hz_ctrl_t CTRL_MISPRED = 4'b1111;
  localparam hz_ctrl_t CTRL_STALL   = 4'b0001;
  localparam hz_ctrl_t CTRL_DRAIN   = 4'b1110;
  localparam hz_ctrl_t CTRL_JR      = 4'b0110;

  function automatic logic is_jr(input logic [6:0] opcode);
    return opcode == OPC_JR;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_load_scoreboard.sv
// rtl/hazard_scoreboard_unit_load_scoreboard.sv - per-register load countdown array and load-use lookup
module hazard_scoreboard_unit_load_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_issue,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic              i_use_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_use_rs2,
  output logic              o_load_stall
);

  localparam int NREGS = 1 << REG_AW;
  localparam int SB_W  = $clog2(LOAD_LAT + 1);
  localparam logic [SB_W-1:0] SB_INIT = SB_W'(LOAD_LAT);
  localparam logic [SB_W-1:0] SB_ONE  = SB_W'(1);

  // Remaining cycles before each register's load result can be forwarded
  logic [SB_W-1:0] r_sb_cnt [NREGS];

  logic w_busy_rs1;
  logic w_busy_rs2;

  // Countdown array: a fresh issue reloads its entry, otherwise nonzero entries tick down; x0 stays 0
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_sb_cnt[i] <= '0;
      end
    end else begin
      r_sb_cnt[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (i_issue && (i_rd == REG_AW'(i))) begin
          r_sb_cnt[i] <= SB_INIT;
        end else if (r_sb_cnt[i] != '0) begin
          r_sb_cnt[i] <= r_sb_cnt[i] - SB_ONE;
        end
      end
    end
  end

  assign w_busy_rs1   = i_use_rs1 && (r_sb_cnt[i_rs1] != '0);
  assign w_busy_rs2   = i_use_rs2 && (r_sb_cnt[i_rs2] != '0);
  assign o_load_stall = w_busy_rs1 | w_busy_rs2;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - load-use / jr / mispredict hazard controller with event counters
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_LAT   = 1,
  parameter int JR_BUBBLES = 1,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        if_id_opcode,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic              if_id_memread,
  input  logic [REG_AW-1:0] if_id_rd,
  input  logic              Wrong_prediction,
  output logic              PC_Write,
  output logic              if_id_Write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int JR_CW = (JR_BUBBLES > 1) ? $clog2(JR_BUBBLES) : 1;
  localparam logic [JR_CW-1:0] JR_INIT = JR_CW'(JR_BUBBLES - 1);
  localparam logic [JR_CW-1:0] JR_ONE  = JR_CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if ((LOAD_LAT < 1) || (LOAD_LAT > 7)) begin : g_bad_load_lat
    $error("hazard_scoreboard_unit: LOAD_LAT must be 1..7");
  end
  if ((JR_BUBBLES < 1) || (JR_BUBBLES > 4)) begin : g_bad_jr_bubbles
    $error("hazard_scoreboard_unit: JR_BUBBLES must be 1..4");
  end

  jr_state_e        r_state;
  jr_state_e        w_state_nxt;
  logic [JR_CW-1:0] r_jr_cnt;
  logic [JR_CW-1:0] w_jr_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  hz_ctrl_t w_ctrl;
  hz_ctrl_t w_out;
  logic     w_load_stall;
  logic     w_issue;

  // A load leaves ID only when it is neither held by a hazard nor squashed by a mispredict
  assign w_issue = if_id_memread & ~w_load_stall & ~Wrong_prediction;

  hazard_scoreboard_unit_load_scoreboard #(
    .REG_AW   (REG_AW),
    .LOAD_LAT (LOAD_LAT)
  ) u_load_scoreboard (
    .clk          (clk),
    .i_rst        (rst),
    .i_issue      (w_issue),
    .i_rd         (if_id_rd),
    .i_rs1        (if_id_rs1),
    .i_use_rs1    (if_id_use_rs1),
    .i_rs2        (if_id_rs2),
    .i_use_rs2    (if_id_use_rs2),
    .o_load_stall (w_load_stall)
  );

  // jr sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_jr_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_jr_cnt <= w_jr_cnt_nxt;
    end
  end

  // Priority mux: mispredict, then load-use stall, then jr drain, then jr entry, else run
  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_state_nxt  = r_state;
    w_jr_cnt_nxt = r_jr_cnt;
    if (Wrong_prediction) begin
      w_ctrl       = CTRL_MISPRED;
      w_state_nxt  = S_IDLE;
      w_jr_cnt_nxt = '0;
    end else if (w_load_stall) begin
      w_ctrl = CTRL_STALL;
    end else if (r_state == S_JR_DRAIN) begin
      w_ctrl       = CTRL_DRAIN;
      w_jr_cnt_nxt = r_jr_cnt - JR_ONE;
      if (r_jr_cnt <= JR_ONE) begin
        w_state_nxt  = S_IDLE;
        w_jr_cnt_nxt = '0;
      end
    end else if (is_jr(if_id_opcode)) begin
      w_ctrl = CTRL_JR;
      if (JR_BUBBLES > 1) begin
        w_state_nxt  = S_JR_DRAIN;
        w_jr_cnt_nxt = JR_INIT;
      end
    end
  end

  // While reset is held the pipeline free-runs with no flushes
  assign w_out       = rst ? w_ctrl : CTRL_RUN;
  assign PC_Write    = w_out.pc_write;
  assign if_id_Write = w_out.if_id_write;
  assign if_id_flush = w_out.if_id_flush;
  assign id_ex_flush = w_out.id_ex_flush;

  // Saturating profiling counters for PC-hold cycles and mispredict cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_out.pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (Wrong_prediction && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule
